uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
Parametrised successor to the fixed 8N1 UART receiver used by the analyzer host link. Adds:
- configurable data width, parity and stop bits
- 3-sample majority vote per bit
- parity, framing and break detection
- mid-stop-bit early completion, so back-to-back frames survive a fast transmitter

It sits between the synchronised host RX pin and the command decoder.

Parameters:
CLK_FREQ, 84_000_000, system clock frequency in Hz
BAUD_RATE, 3_000_000, line rate in baud
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; 1 or 2
SYNC_STAGES, 2, RX input synchroniser depth; minimum 2

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
rx  in  1  asynchronous serial line; idles high
rx_data  out  DATA_BITS  received word, LSB first on the line; held until the next frame completes
rx_data_valid  out  1  one-cycle pulse when a frame completes
rx_parity_error  out  1  qualifies rx_data_valid: parity mismatch
rx_frame_error  out  1  qualifies rx_data_valid: a stop bit was sampled low
rx_break  out  1  qualifies rx_data_valid: break condition
rx_busy  out  1  high from start-edge detect until return to IDLE

Behaviour:
- Reset: the synchroniser chain resets to 1.
  - rx_data resets to 0; rx_data_valid and all three error flags reset to 0; rx_busy resets to 0; state resets to IDLE.
  - Reset asserted mid-frame aborts the frame; no pulse is emitted.
- Timing constants:
  - BIT_CYCLES = CLK_FREQ/BAUD_RATE (integer division).
  - MID = BIT_CYCLES/2.
  - Elaboration fails if BIT_CYCLES < 4 or any parameter is out of range.
- Per-bit counter:
  - cnt counts 0..BIT_CYCLES-1 and wraps to 0 at each bit boundary.
  - Samples are taken at cnt = MID-1, MID and MID+1.
  - The bit value is the majority of the three samples, decided at cnt = MID+1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE:
  - A falling edge on the synchronised line (previous sample 1, current sample 0) moves to START with cnt = 0.
  - A line already low out of reset or out of BREAK_WAIT does not trigger a start.
- START:
  - Majority 0 → DATA.
  - Majority 1 → glitch; return to IDLE with no pulse and no flags.
- DATA:
  - DATA_BITS bits are shifted in LSB first, then the state moves to PARITY if PARITY != 0, otherwise to STOP.
- PARITY:
  - The parity flag is computed as the XOR of the data bits and the parity bit.
  - Odd mode: error when the XOR result is 0. Even mode: error when the XOR result is 1.
- STOP (decided at each stop bit's MID+1):
  - With STOP_BITS = 2, a low first stop bit latches a frame error, and the second stop bit is still sampled.
  - At the final stop decision, in the same cycle:
    - rx_data loads the assembled word
    - rx_data_valid pulses in the next cycle
    - flags are registered alongside it
    - the state returns to IDLE
  - The remaining half stop bit is not waited for, so a new start edge is accepted immediately.
- Break:
  - Condition: all data bits 0, parity bit 0 (if present) and the final stop bit 0.
  - Result: rx_break = rx_frame_error = 1, rx_data = 0, and the state goes to BREAK_WAIT.
  - BREAK_WAIT holds (rx_busy stays 1) until the synchronised line is high for one full BIT_CYCLES, then returns to IDLE.
  - An arbitrarily long break therefore yields exactly one event.
- Error flags are valid only in the rx_data_valid cycle and are 0 otherwise.
- Latency: with edge detect at cycle t0, rx_data_valid is high at t0 + (N-1)·BIT_CYCLES + MID + 3, where N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
- Counter width is $clog2(BIT_CYCLES+1). The bit index width is $clog2(DATA_BITS+1).

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN
  - the state encoding
  - function bit_cycles(clk, baud)
  - the parameter range checks
- Sub-module uart_rx_bit_sampler contains:
  - the synchroniser chain
  - the falling-edge detector
  - the per-bit counter with the 3-point majority vote
- The sampler outputs a bit_valid strobe and bit_value. The FSM lives in uart_rx_frame.

Test Plan:
1. Defaults, 8N1, send 0xA5 at 3 Mbaud → one rx_data_valid pulse with rx_data = 0xA5 and all flags 0; latency = 9·28 + 14 + 3 cycles after edge detect.
2. PARITY = 2, send 0x07:
   - parity bit 1 → valid, parity error 0
   - parity bit 0 → rx_data = 0x07 with rx_parity_error = 1
3. Send a 10-cycle low glitch on an idle line → no pulse, rx_busy back to 0 within 16 cycles. Then send 0x3C with its stop bit forced low → rx_data = 0x3C, rx_frame_error = 1.
4. Invert rx for one cycle at the MID sample of data bit 3 of 0x55 → rx_data = 0x55, no errors. Then send 16 back-to-back frames with zero idle, transmitter 2% fast → all 16 bytes received in order.
5. Hold the line low for 40 bit times, then release → exactly one pulse with rx_data = 0, rx_break = 1, rx_frame_error = 1. A following 0x81 is received correctly.
6. Assert reset during data bit 4 → all outputs reset immediately. The next clean frame 0x12 is received normally. Repeat with DATA_BITS = 5, STOP_BITS = 2 and send 0x1F → rx_data = 5'h1F.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// receiver state encoding, bit timing helper and parameter legality check.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK_WAIT
   } rx_state_t;

   function automatic int bit_cycles(input int clk, input int baud);
      return (baud > 0) ? clk / baud : 0;
   endfunction

   function automatic bit params_ok(input int clk, input int baud, input int data_bits,
                                    input int parity, input int stop_bits, input int sync_stages);
      return (bit_cycles(clk, baud) >= 4) &&
             (data_bits >= 5) && (data_bits <= 9) &&
             (parity >= PAR_NONE) && (parity <= PAR_EVEN) &&
             (stop_bits >= 1) && (stop_bits <= 2) &&
             (sync_stages >= 2);
   endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// RX line front end: synchroniser, start-edge detector and per-bit
// counter producing a 3-sample majority-voted bit value at MID+1.
module uart_rx_bit_sampler
   import uart_pkg::*;
#(
   parameter int BIT_CYCLES  = 28,
   parameter int SYNC_STAGES = 2
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic rx,
   input  logic restart,
   output logic rx_sync,
   output logic fall_edge,
   output logic bit_valid,
   output logic bit_value,
   output logic bit_end
);

   localparam int CNT_W = $clog2(BIT_CYCLES + 1);
   localparam int MID   = BIT_CYCLES / 2;

   logic [SYNC_STAGES-1:0] sync_chain;
   logic [SYNC_STAGES-1:0] primed;
   logic                   rx_prev;
   logic [CNT_W-1:0]       cnt;
   logic                   sample_early;
   logic                   sample_mid;

   // The edge history only takes real line samples once the reset ones have
   // drained out of the chain, so a line held low from reset never looks like a start.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_chain <= '1;
         primed     <= '0;
         rx_prev    <= 1'b0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], rx};
         primed     <= {primed[SYNC_STAGES-2:0], 1'b1};
         rx_prev    <= rx_sync & primed[SYNC_STAGES-1];
      end
   end

   assign rx_sync   = sync_chain[SYNC_STAGES-1];
   assign fall_edge = rx_prev & ~rx_sync;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt          <= '0;
         sample_early <= 1'b1;
         sample_mid   <= 1'b1;
      end else begin
         if (restart || (cnt == CNT_W'(BIT_CYCLES - 1)))
            cnt <= '0;
         else
            cnt <= cnt + CNT_W'(1);
         if (cnt == CNT_W'(MID - 1))
            sample_early <= rx_sync;
         if (cnt == CNT_W'(MID))
            sample_mid <= rx_sync;
      end
   end

   assign bit_valid = (cnt == CNT_W'(MID + 1));
   assign bit_end   = (cnt == CNT_W'(BIT_CYCLES - 1));
   assign bit_value = (sample_early & sample_mid) | (sample_early & rx_sync) | (sample_mid & rx_sync);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART frame receiver with parity, framing and break detection;
// completes at the middle of the final stop bit so back-to-back frames are kept.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int CLK_FREQ    = 84_000_000,
   parameter int BAUD_RATE   = 3_000_000,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_data_valid,
   output logic                 rx_parity_error,
   output logic                 rx_frame_error,
   output logic                 rx_break,
   output logic                 rx_busy
);

   localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
   localparam int IDX_W      = $clog2(DATA_BITS + 1);

   if (!params_ok(CLK_FREQ, BAUD_RATE, DATA_BITS, PARITY, STOP_BITS, SYNC_STAGES)) begin : g_bad_params
      $error("uart_rx_frame: parameter set out of range");
   end

   rx_state_t            state, next_state;
   logic                 rx_sync, fall_edge, bit_valid, bit_value, bit_end;
   logic                 restart;
   logic [DATA_BITS-1:0] shift_reg;
   logic [IDX_W-1:0]     bit_idx;
   logic                 stop_idx;
   logic                 par_bit;
   logic                 frame_err_q;
   logic                 last_stop, is_break, par_xor, parity_err;
   logic                 frame_begin, shift_en, par_capture, stop_sample, frame_done;

   uart_rx_bit_sampler #(
      .BIT_CYCLES (BIT_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sampler (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .rx       (rx),
      .restart  (restart),
      .rx_sync  (rx_sync),
      .fall_edge(fall_edge),
      .bit_valid(bit_valid),
      .bit_value(bit_value),
      .bit_end  (bit_end)
   );

   assign last_stop  = (STOP_BITS == 1) || stop_idx;
   assign is_break   = (shift_reg == '0) && !par_bit && !bit_value;
   assign par_xor    = (^shift_reg) ^ par_bit;
   assign parity_err = (PARITY == PAR_ODD)  ? ~par_xor :
                       (PARITY == PAR_EVEN) ?  par_xor : 1'b0;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:
            if (fall_edge) next_state = ST_START;
         ST_START:
            if (bit_valid) next_state = bit_value ? ST_IDLE : ST_DATA;
         ST_DATA:
            if (bit_valid && (bit_idx == IDX_W'(DATA_BITS - 1)))
               next_state = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
         ST_PARITY:
            if (bit_valid) next_state = ST_STOP;
         ST_STOP:
            if (bit_valid && last_stop) next_state = is_break ? ST_BREAK_WAIT : ST_IDLE;
         ST_BREAK_WAIT:
            if (bit_end && rx_sync) next_state = ST_IDLE;
         default:
            next_state = ST_IDLE;
      endcase
   end

   // Entering break-wait and every low sample inside it restart the bit
   // counter, so leaving requires one uninterrupted high bit time.
   always_comb begin
      frame_begin = (state == ST_IDLE) && fall_edge;
      shift_en    = (state == ST_DATA) && bit_valid;
      par_capture = (state == ST_PARITY) && bit_valid;
      stop_sample = (state == ST_STOP) && bit_valid;
      frame_done  = stop_sample && last_stop;
      restart     = frame_begin || (frame_done && is_break) ||
                    ((state == ST_BREAK_WAIT) && !rx_sync);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         shift_reg       <= '0;
         bit_idx         <= '0;
         stop_idx        <= 1'b0;
         par_bit         <= 1'b0;
         frame_err_q     <= 1'b0;
         rx_data         <= '0;
         rx_data_valid   <= 1'b0;
         rx_parity_error <= 1'b0;
         rx_frame_error  <= 1'b0;
         rx_break        <= 1'b0;
      end else begin
         rx_data_valid   <= frame_done;
         rx_parity_error <= 1'b0;
         rx_frame_error  <= 1'b0;
         rx_break        <= 1'b0;
         if (frame_begin) begin
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            par_bit     <= 1'b0;
            frame_err_q <= 1'b0;
         end
         if (shift_en) begin
            shift_reg <= {bit_value, shift_reg[DATA_BITS-1:1]};
            bit_idx   <= bit_idx + IDX_W'(1);
         end
         if (par_capture)
            par_bit <= bit_value;
         if (stop_sample && !last_stop) begin
            stop_idx <= 1'b1;
            if (!bit_value) frame_err_q <= 1'b1;
         end
         if (frame_done) begin
            rx_data         <= shift_reg;
            rx_parity_error <= parity_err;
            rx_frame_error  <= frame_err_q | ~bit_value;
            rx_break        <= is_break;
         end
      end
   end

   assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: three configurations (8N1, 8E1, 5N2)
// driven by a serial transmitter and checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_frame;

   localparam real BIT_NS      = 280.0;
   localparam int  BIT_CYC     = 28;
   localparam int  LATENCY_8N1 = 2 + 9 * BIT_CYC + BIT_CYC / 2 + 3;

   logic       sysClk  = 1'b0;
   logic       sysRstN = 1'b1;
   logic       rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
   logic [7:0] data0, data1;
   logic [4:0] data2;
   logic       valid0, perr0, ferr0, brk0, busy0;
   logic       valid1, perr1, ferr1, brk1, busy1;
   logic       valid2, perr2, ferr2, brk2, busy2;

   int errorCount = 0;
   int checkCount = 0;
   int cyc        = 0;
   int leakCount  = 0;
   int expTotal[3]     = '{0, 0, 0};
   int pulseCount[3]   = '{0, 0, 0};
   int lastValidCyc[3] = '{0, 0, 0};
   int startCyc;
   logic [11:0] expQ0[$], expQ1[$], expQ2[$];

   uart_rx_frame dut0 (
      .sys_clk(sysClk), .sys_rst_n(sysRstN), .rx(rx0),
      .rx_data(data0), .rx_data_valid(valid0), .rx_parity_error(perr0),
      .rx_frame_error(ferr0), .rx_break(brk0), .rx_busy(busy0)
   );

   uart_rx_frame #(.PARITY(2)) dut1 (
      .sys_clk(sysClk), .sys_rst_n(sysRstN), .rx(rx1),
      .rx_data(data1), .rx_data_valid(valid1), .rx_parity_error(perr1),
      .rx_frame_error(ferr1), .rx_break(brk1), .rx_busy(busy1)
   );

   uart_rx_frame #(.DATA_BITS(5), .STOP_BITS(2)) dut2 (
      .sys_clk(sysClk), .sys_rst_n(sysRstN), .rx(rx2),
      .rx_data(data2), .rx_data_valid(valid2), .rx_parity_error(perr2),
      .rx_frame_error(ferr2), .rx_break(brk2), .rx_busy(busy2)
   );

   always #5 sysClk = ~sysClk;
   always @(posedge sysClk) cyc++;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Frame-level reference: {break, frame error, parity error, data[8:0]}
   function automatic logic [11:0] modelFrame(input int dataBits, input int parity, input int stopBits,
                                              input logic [8:0] data, input logic parBit, input logic [1:0] stops);
      logic [8:0] d;
      int         ones;
      logic       perr, ferr, brk, finalStop;
      d         = data & 9'((1 << dataBits) - 1);
      ones      = $countones(d) + int'(parBit);
      perr      = (parity == 1) ? (ones % 2 == 0) : (parity == 2) ? (ones % 2 == 1) : 1'b0;
      finalStop = stops[stopBits-1];
      ferr      = !stops[0] || !finalStop;
      brk       = (d == 0) && ((parity == 0) || !parBit) && !finalStop;
      return {brk, ferr, perr, d};
   endfunction

   task automatic driveLine(input int sel, input logic v);
      case (sel)
         0: rx0 = v;
         1: rx1 = v;
         default: rx2 = v;
      endcase
   endtask

   task automatic applyStimulus(input int sel, input int dataBits, input int parity, input int stopBits,
                                input logic [8:0] data, input logic parBit, input logic [1:0] stops,
                                input real bitNs, input int glitchBit);
      driveLine(sel, 1'b0);
      #(bitNs);
      for (int i = 0; i < dataBits; i++) begin
         driveLine(sel, data[i]);
         if (i == glitchBit) begin
            #(bitNs / 2.0);
            driveLine(sel, ~data[i]);
            #10;
            driveLine(sel, data[i]);
            #(bitNs / 2.0 - 10.0);
         end else begin
            #(bitNs);
         end
      end
      if (parity != 0) begin
         driveLine(sel, parBit);
         #(bitNs);
      end
      for (int s = 0; s < stopBits; s++) begin
         driveLine(sel, stops[s]);
         #(bitNs);
      end
      driveLine(sel, 1'b1);
   endtask

   task automatic pushExpect(input int sel, input logic [11:0] rec);
      expTotal[sel]++;
      case (sel)
         0: expQ0.push_back(rec);
         1: expQ1.push_back(rec);
         default: expQ2.push_back(rec);
      endcase
   endtask

   task automatic sendExpect(input int sel, input logic [8:0] data, input logic parBit,
                             input logic [1:0] stops, input real bitNs, input int glitchBit);
      int db, par, sb;
      case (sel)
         0: begin db = 8; par = 0; sb = 1; end
         1: begin db = 8; par = 2; sb = 1; end
         default: begin db = 5; par = 0; sb = 2; end
      endcase
      pushExpect(sel, modelFrame(db, par, sb, data, parBit, stops));
      applyStimulus(sel, db, par, sb, data, parBit, stops, bitNs, glitchBit);
   endtask

   task automatic observe(input int sel, input logic valid, input logic [11:0] rec);
      int          avail;
      logic [11:0] expRec;
      if (!valid) begin
         if (rec[11:9] != 3'b000) leakCount++;
         return;
      end
      pulseCount[sel]++;
      lastValidCyc[sel] = cyc;
      case (sel)
         0: avail = expQ0.size();
         1: avail = expQ1.size();
         default: avail = expQ2.size();
      endcase
      if (avail == 0) begin
         checkOutput($sformatf("dut%0d extra pulse", sel), pulseCount[sel], expTotal[sel]);
      end else begin
         case (sel)
            0: expRec = expQ0.pop_front();
            1: expRec = expQ1.pop_front();
            default: expRec = expQ2.pop_front();
         endcase
         checkOutput($sformatf("dut%0d frame", sel), rec, expRec);
      end
   endtask

   always @(negedge sysClk) begin
      observe(0, valid0, {brk0, ferr0, perr0, 1'b0, data0});
      observe(1, valid1, {brk1, ferr1, perr1, 1'b0, data1});
      observe(2, valid2, {brk2, ferr2, perr2, 4'b0000, data2});
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errorCount);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [8:0]  rnd;
      logic [1:0]  stp;
      rx2 = 1'b0;
      #2 sysRstN = 1'b0;
      #30;
      checkOutput("reset data0", data0, 0);
      checkOutput("reset valid0", valid0, 0);
      checkOutput("reset flags0", {perr0, ferr0, brk0}, 0);
      checkOutput("reset busy0", busy0, 0);
      checkOutput("reset data1", data1, 0);
      checkOutput("reset data2", data2, 0);
      checkOutput("reset busy2", busy2, 0);
      @(negedge sysClk) sysRstN = 1'b1;

      // Line held low through reset release must not start a frame
      repeat (2 * BIT_CYC) @(negedge sysClk);
      checkOutput("low line from reset busy2", busy2, 0);
      rx2 = 1'b1;
      repeat (10) @(negedge sysClk);

      // 8N1 single byte with latency
      startCyc = cyc;
      sendExpect(0, 9'h0A5, 1'b0, 2'b11, BIT_NS, -1);
      repeat (20) @(negedge sysClk);
      checkOutput("t1 frames", pulseCount[0], expTotal[0]);
      checkOutput("t1 latency", lastValidCyc[0] - startCyc, LATENCY_8N1);

      // Even parity: good then bad parity bit, then random frames
      sendExpect(1, 9'h007, 1'b1, 2'b11, BIT_NS, -1);
      repeat (30) @(negedge sysClk);
      sendExpect(1, 9'h007, 1'b0, 2'b11, BIT_NS, -1);
      repeat (30) @(negedge sysClk);
      for (int k = 0; k < 8; k++) begin
         rnd = ($urandom_range(0, 5) == 0) ? 9'h000 : 9'($urandom_range(0, 255));
         stp = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
         sendExpect(1, rnd, 1'($urandom_range(0, 1)), stp, BIT_NS, -1);
         repeat (60) @(negedge sysClk);
      end
      checkOutput("t2 frames", pulseCount[1], expTotal[1]);

      // Short glitch, then a frame with its stop bit low
      driveLine(0, 1'b0);
      repeat (10) @(negedge sysClk);
      driveLine(0, 1'b1);
      repeat (16) @(negedge sysClk);
      checkOutput("t3 busy after glitch", busy0, 0);
      checkOutput("t3 glitch pulses", pulseCount[0], expTotal[0]);
      sendExpect(0, 9'h03C, 1'b0, 2'b00, BIT_NS, -1);
      repeat (30) @(negedge sysClk);

      // Mid-bit inversion, then 16 back-to-back frames from a 2% fast transmitter
      sendExpect(0, 9'h055, 1'b0, 2'b11, BIT_NS, 3);
      repeat (30) @(negedge sysClk);
      for (int k = 0; k < 16; k++)
         sendExpect(0, 9'($urandom_range(0, 255)), 1'b0, 2'b11, BIT_NS * 0.98, -1);
      repeat (60) @(negedge sysClk);
      checkOutput("t4 frames", pulseCount[0], expTotal[0]);

      // Long break yields one event
      pushExpect(0, modelFrame(8, 0, 1, 9'h000, 1'b0, 2'b00));
      driveLine(0, 1'b0);
      repeat (20 * BIT_CYC) @(negedge sysClk);
      checkOutput("t5 busy in break", busy0, 1);
      repeat (20 * BIT_CYC) @(negedge sysClk);
      driveLine(0, 1'b1);
      repeat (2 * BIT_CYC) @(negedge sysClk);
      checkOutput("t5 busy after break", busy0, 0);
      checkOutput("t5 break pulses", pulseCount[0], expTotal[0]);
      sendExpect(0, 9'h081, 1'b0, 2'b11, BIT_NS, -1);
      repeat (30) @(negedge sysClk);

      // Reset during data bit 4 aborts the frame
      fork
         applyStimulus(0, 8, 0, 1, 9'h0C3, 1'b0, 2'b11, BIT_NS, -1);
         begin
            #(BIT_NS * 5.5);
            sysRstN = 1'b0;
            #2;
            checkOutput("t6 data after reset", data0, 0);
            checkOutput("t6 busy after reset", busy0, 0);
            checkOutput("t6 valid after reset", valid0, 0);
         end
      join
      repeat (5) @(negedge sysClk);
      sysRstN = 1'b1;
      repeat (10) @(negedge sysClk);
      checkOutput("t6 aborted pulses", pulseCount[0], expTotal[0]);
      sendExpect(0, 9'h012, 1'b0, 2'b11, BIT_NS, -1);
      repeat (30) @(negedge sysClk);

      // Five data bits, two stop bits
      sendExpect(2, 9'h01F, 1'b0, 2'b11, BIT_NS, -1);
      repeat (60) @(negedge sysClk);
      for (int k = 0; k < 8; k++) begin
         rnd = ($urandom_range(0, 4) == 0) ? 9'h000 : 9'($urandom_range(0, 31));
         stp = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
         sendExpect(2, rnd, 1'b0, stp, BIT_NS, -1);
         repeat (60) @(negedge sysClk);
      end

      checkOutput("final frames dut0", pulseCount[0], expTotal[0]);
      checkOutput("final frames dut1", pulseCount[1], expTotal[1]);
      checkOutput("final frames dut2", pulseCount[2], expTotal[2]);
      checkOutput("flags outside valid", leakCount, 0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
